// File: rtl/rx_deser_gen2.sv
// rx_deser_gen2: UART-style receive deserializer.
// Captures one majority-voted bit per bit period into a shift register and
// tracks running parity and bit count. It pulses data_done once per frame and
// flags strobes that arrive after the frame has completed.
module rx_deser_gen2 #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_count,
  input  logic                  sampled_bit,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_done,
  output logic                  par_calc,
  output logic [3:0]            bit_idx,
  output logic                  overrun
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pdata_q, pdata_d;
  logic [3:0]              idx_q, idx_d;
  logic                    par_q, par_d;
  logic                    ovr_q, ovr_d;
  logic                    done_q, done_d;
  logic                    strb_lvl_q;

  logic [PRESCALE_W:0]     strobe_pt;
  logic                    strobe_lvl;
  logic                    strobe;

  // Shift one received bit into the frame in the configured bit order.
  function automatic logic [DATA_WIDTH-1:0] shift_in(
    input logic [DATA_WIDTH-1:0] cur,
    input logic                  b
  );
    if (MSB_FIRST != 0) begin
      return {cur[DATA_WIDTH-2:0], b};
    end else begin
      return {b, cur[DATA_WIDTH-1:1]};
    end
  endfunction

  // The sample point sits two edges past mid-bit; one extra bit keeps the
  // sum from wrapping at large prescale values.
  assign strobe_pt  = {1'b0, prescale >> 1} + (PRESCALE_W+1)'(2);
  assign strobe_lvl = enable & ({1'b0, edge_count} == strobe_pt);
  // Only the rising edge counts, so a stalled edge_count captures once.
  assign strobe     = strobe_lvl & ~strb_lvl_q;

  // Next-state logic: start has priority over everything, including a strobe.
  always_comb begin
    state_d = state_q;
    pdata_d = pdata_q;
    idx_d   = idx_q;
    par_d   = par_q;
    ovr_d   = ovr_q;
    done_d  = 1'b0;
    if (start) begin
      state_d = SHIFT;
      idx_d   = 4'd0;
      par_d   = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SHIFT: begin
          if (strobe) begin
            pdata_d = shift_in(pdata_q, sampled_bit);
            idx_d   = idx_q + 4'd1;
            par_d   = par_q ^ sampled_bit;
            if (idx_q == 4'(DATA_WIDTH - 1)) begin
              state_d = HOLD;
              done_d  = 1'b1;
            end
          end
        end
        HOLD: begin
          if (strobe) begin
            ovr_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pdata_q    <= '1;
      idx_q      <= 4'd0;
      par_q      <= 1'b0;
      ovr_q      <= 1'b0;
      done_q     <= 1'b0;
      strb_lvl_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pdata_q    <= pdata_d;
      idx_q      <= idx_d;
      par_q      <= par_d;
      ovr_q      <= ovr_d;
      done_q     <= done_d;
      strb_lvl_q <= strobe_lvl;
    end
  end

  assign p_data    = pdata_q;
  assign data_done = done_q;
  assign par_calc  = par_q;
  assign bit_idx   = idx_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_rx_deser_gen2.sv
// Testbench for rx_deser_gen2: three instances (W8 LSB-first, W8 MSB-first,
// W7 LSB-first) share the bit-period stimulus. Expected frames are queued
// when issued and checked by a monitor whenever data_done fires.
module tb_rx_deser_gen2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start_v;
  logic [2:0] en_v;
  logic [5:0] prescale;
  logic [5:0] edge_count;
  logic       sampled_bit;

  logic [7:0] pd0, pd1;
  logic [6:0] pd2;
  logic [2:0] done_v, par_v, ovr_v;
  logic [3:0] idx0, idx1, idx2;

  logic [8:0] pd_w  [3];
  logic [3:0] idx_w [3];

  assign pd_w[0]  = {1'b0, pd0};
  assign pd_w[1]  = {1'b0, pd1};
  assign pd_w[2]  = {2'b00, pd2};
  assign idx_w[0] = idx0;
  assign idx_w[1] = idx1;
  assign idx_w[2] = idx2;

  typedef struct {
    int         d;
    logic [8:0] pd;
    logic       par;
    logic [3:0] idx;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rx_deser_gen2 #(.DATA_WIDTH(8), .PRESCALE_W(6), .MSB_FIRST(0)) u_lsb8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .enable(en_v[0]),
    .prescale(prescale), .edge_count(edge_count), .sampled_bit(sampled_bit),
    .p_data(pd0), .data_done(done_v[0]), .par_calc(par_v[0]),
    .bit_idx(idx0), .overrun(ovr_v[0]));

  rx_deser_gen2 #(.DATA_WIDTH(8), .PRESCALE_W(6), .MSB_FIRST(1)) u_msb8 (
    .clk(clk), .rst(rst), .start(start_v[1]), .enable(en_v[1]),
    .prescale(prescale), .edge_count(edge_count), .sampled_bit(sampled_bit),
    .p_data(pd1), .data_done(done_v[1]), .par_calc(par_v[1]),
    .bit_idx(idx1), .overrun(ovr_v[1]));

  rx_deser_gen2 #(.DATA_WIDTH(7), .PRESCALE_W(6), .MSB_FIRST(0)) u_lsb7 (
    .clk(clk), .rst(rst), .start(start_v[2]), .enable(en_v[2]),
    .prescale(prescale), .edge_count(edge_count), .sampled_bit(sampled_bit),
    .p_data(pd2), .data_done(done_v[2]), .par_calc(par_v[2]),
    .bit_idx(idx2), .overrun(ovr_v[2]));

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pops one expected frame for every data_done pulse seen on any instance.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (done_v[d]) begin
          if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: dut%0d pulsed with p_data=%0h, expected no pulse", d, pd_w[d]);
          end else begin
            e = sbq.pop_front();
            chk("done_dut", 16'(d), 16'(e.d));
            chk("done_p_data", 16'(pd_w[d]), 16'(e.pd));
            chk("done_par", 16'(par_v[d]), 16'(e.par));
            chk("done_bit_idx", 16'(idx_w[d]), 16'(e.idx));
          end
        end
      end
    end
  endtask

  task automatic push(input int d, input logic [8:0] pd, input logic par, input logic [3:0] idx);
    exp_t e;
    e.d = d; e.pd = pd; e.par = par; e.idx = idx;
    sbq.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 16'(sbq.size()), 16'd0);
  endtask

  // One-cycle start pulse; optionally coincident with a qualified strobe.
  task automatic do_start(input int d, input bit at_strobe);
    @(negedge clk);
    start_v[d] = 1'b1;
    en_v[d]    = at_strobe;
    edge_count = at_strobe ? 6'((int'(prescale) >> 1) + 2) : 6'd0;
    @(negedge clk);
    start_v[d] = 1'b0;
    en_v[d]    = 1'b0;
    edge_count = 6'd0;
  endtask

  // One bit period; the sample edge value is held for 'hold' cycles.
  task automatic send_bit(input int d, input logic b, input logic en, input int hold);
    int sp;
    sp = (int'(prescale) >> 1) + 2;
    for (int e = 0; e < int'(prescale); e++) begin
      for (int r = 0; r < ((e == sp) ? hold : 1); r++) begin
        @(negedge clk);
        en_v[d]     = en;
        edge_count  = 6'(e);
        sampled_bit = b;
      end
    end
  endtask

  // seq[n-1] is the first bit on the line, so literals read in send order.
  task automatic send_seq(input int d, input logic [8:0] seq, input int n, input int hold);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(d, seq[i], 1'b1, hold);
    end
    @(negedge clk);
    en_v[d] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    start_v     = 3'b000;
    en_v        = 3'b000;
    prescale    = 6'd8;
    edge_count  = 6'd0;
    sampled_bit = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("rst_p_data0", 16'(pd0), 16'hFF);
    chk("rst_p_data1", 16'(pd1), 16'hFF);
    chk("rst_p_data2", 16'(pd2), 16'h7F);
    chk("rst_done", 16'(done_v), 16'd0);
    chk("rst_par", 16'(par_v), 16'd0);
    chk("rst_bit_idx", 16'(idx0), 16'd0);
    chk("rst_overrun", 16'(ovr_v), 16'd0);
    rst = 1'b0;

    // W8 LSB-first, strobe edge held 3 cycles: still one capture per bit.
    do_start(0, 1'b0);
    push(0, 9'hA5, 1'b0, 4'd8);
    send_seq(0, 9'b010100101, 8, 3);
    drain();
    chk("a5_bit_idx", 16'(idx0), 16'd8);
    chk("a5_overrun", 16'(ovr_v[0]), 16'd0);

    // Extra strobe after completion sets overrun and leaves data alone.
    send_bit(0, 1'b0, 1'b1, 1);
    @(negedge clk);
    en_v[0] = 1'b0;
    chk("ovr_set", 16'(ovr_v[0]), 16'd1);
    chk("ovr_p_data", 16'(pd0), 16'hA5);
    chk("ovr_bit_idx", 16'(idx0), 16'd8);
    do_start(0, 1'b0);
    chk("ovr_clear", 16'(ovr_v[0]), 16'd0);
    chk("restart_idx", 16'(idx0), 16'd0);
    chk("restart_keeps_data", 16'(pd0), 16'hA5);

    // Reset after four bits aborts the frame without a done pulse.
    send_seq(0, 9'b000001101, 4, 1);
    chk("four_bits_idx", 16'(idx0), 16'd4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_p_data", 16'(pd0), 16'hFF);
    chk("midrst_idx", 16'(idx0), 16'd0);
    chk("midrst_par", 16'(par_v[0]), 16'd0);
    chk("midrst_done", 16'(done_v[0]), 16'd0);
    rst = 1'b0;
    send_bit(0, 1'b1, 1'b1, 1);
    chk("idle_ignores_strobe", 16'(idx0), 16'd0);
    chk("idle_p_data", 16'(pd0), 16'hFF);

    // Start coincident with a strobe mid-frame: the strobe is dropped.
    do_start(0, 1'b0);
    send_seq(0, 9'b000000011, 2, 1);
    chk("two_bits_idx", 16'(idx0), 16'd2);
    do_start(0, 1'b1);
    chk("start_wins_idx", 16'(idx0), 16'd0);
    chk("start_wins_par", 16'(par_v[0]), 16'd0);
    push(0, 9'h00B, 1'b1, 4'd8);
    send_seq(0, 9'b011010000, 8, 1);
    drain();

    // MSB-first instance.
    do_start(1, 1'b0);
    push(1, 9'hA5, 1'b0, 4'd8);
    send_seq(1, 9'b010100101, 8, 1);
    drain();
    do_start(1, 1'b0);
    push(1, 9'hC0, 1'b0, 4'd8);
    send_seq(1, 9'b011000000, 8, 1);
    drain();

    // Seven-bit instance.
    do_start(2, 1'b0);
    push(2, 9'h007, 1'b1, 4'd7);
    send_seq(2, 9'b001110000, 7, 1);
    drain();
    chk("w7_bit_idx", 16'(idx2), 16'd7);

    // prescale 63 (sample at 33) with enable low for two bit periods.
    prescale = 6'd63;
    do_start(0, 1'b0);
    send_seq(0, 9'b000000010, 3, 1);
    send_bit(0, 1'b1, 1'b0, 1);
    send_bit(0, 1'b1, 1'b0, 1);
    chk("en_low_idx", 16'(idx0), 16'd3);
    push(0, 9'h05A, 1'b0, 4'd8);
    send_seq(0, 9'b000011010, 5, 1);
    drain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
